// File: rtl/sv32_walk_mem_responder_pkg.sv
// Shared types and helpers for the Sv32 walker PTE fetch responder.
package sv32_walk_mem_responder_pkg;

  localparam logic [1:0] SV32_PTE_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } resp_state_e;

  // Word-aligned and inside [base, base+size); 33-bit sum so a window ending at 2^32 does not wrap.
  function automatic logic pte_addr_legal(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return ((addr[1:0] & SV32_PTE_ALIGN_MASK) == 2'b00) && (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/sv32_walk_mem_responder_if.sv
// Request/response channel used both for the walker port and the memory bus port.
interface sv32_walk_mem_responder_if;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, output addr, output wstrb, input ready, input rdata);
  modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/sv32_walk_mem_responder_tag_ram.sv
// Direct-mapped tag/payload store for the optional PTE cache (SV32_PTE_CACHE_EN).
// Valid bits clear asynchronously on resetn low; lookups are combinational.
`ifdef SV32_PTE_CACHE_EN
module sv32_walk_mem_responder_tag_ram #(
  parameter int unsigned TAG_RAM_ADDR_WIDTH = 4,
  parameter int unsigned PAYLOAD_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [29:0]              lookup_word,
  output logic                     hit,
  output logic [PAYLOAD_WIDTH-1:0] hit_data,
  input  logic                     fill_en,
  input  logic [29:0]              fill_word,
  input  logic [PAYLOAD_WIDTH-1:0] fill_data
);
  localparam int unsigned N  = 1 << TAG_RAM_ADDR_WIDTH;
  localparam int unsigned TW = 30 - TAG_RAM_ADDR_WIDTH;

  logic [N-1:0]             valid_q;
  logic [TW-1:0]            tag_q  [N];
  logic [PAYLOAD_WIDTH-1:0] data_q [N];

  logic [TAG_RAM_ADDR_WIDTH-1:0] l_idx, f_idx;
  logic [TW-1:0]                 l_tag, f_tag;

  assign l_idx = lookup_word[TAG_RAM_ADDR_WIDTH-1:0];
  assign l_tag = lookup_word[29:TAG_RAM_ADDR_WIDTH];
  assign f_idx = fill_word[TAG_RAM_ADDR_WIDTH-1:0];
  assign f_tag = fill_word[29:TAG_RAM_ADDR_WIDTH];

  // Valid bits: cleared by reset/flush, set on fill.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= '0;
    else if (fill_en) valid_q[f_idx] <= 1'b1;
  end

  // Tag and payload storage, no reset needed behind the valid bits.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[f_idx]  <= f_tag;
      data_q[f_idx] <= fill_data;
    end
  end

  assign hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign hit_data = data_q[l_idx];
endmodule
`endif

// File: rtl/sv32_walk_mem_responder.sv
// Sv32 page-table walker PTE fetch responder: range-checks each walker request, reads the PTE
// over a read-only bus port and returns it with a one-cycle ready strobe.
// Optional PTE cache compiled in with SV32_PTE_CACHE_EN.
module sv32_walk_mem_responder
  import sv32_walk_mem_responder_pkg::*;
#(
  parameter logic [31:0] PT_BASE           = 32'h8000_0000,
  parameter logic [31:0] PT_SIZE           = 32'h0800_0000,
  parameter int unsigned PTE_CACHE_ENTRIES = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tlb_flush,
  sv32_walk_mem_responder_if.slave     walk,
  sv32_walk_mem_responder_if.master    mem,
  output logic [31:0]                  walk_req_count
);
  localparam int unsigned IDX_W = $clog2(PTE_CACHE_ENTRIES);

  resp_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] count_q, count_d;
  logic        ready_q, ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic        fault_q, fault_d;
  logic        abandon_q, abandon_d;
  logic        legal;
  logic        cache_hit;
  logic [31:0] cache_data;

  assign legal = pte_addr_legal(walk.addr, PT_BASE, PT_SIZE);

`ifdef SV32_PTE_CACHE_EN
  logic cache_rstn;
  logic fill_en;
  assign cache_rstn = resetn & ~tlb_flush;
  assign fill_en    = (state_q == ST_BUS) && !fault_q && mem.ready;

  sv32_walk_mem_responder_tag_ram #(
    .TAG_RAM_ADDR_WIDTH (IDX_W),
    .PAYLOAD_WIDTH      (32)
  ) u_tag_ram (
    .clk         (clk),
    .resetn      (cache_rstn),
    .lookup_word (walk.addr[31:2]),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (fill_en),
    .fill_word   (addr_q[31:2]),
    .fill_data   (mem.rdata)
  );
`else
  logic unused_cfg;
  assign unused_cfg = tlb_flush ^ IDX_W[0];
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Next-state and next-output logic.
  // A faulting request passes through BUS with no bus request so its strobe lands two cycles after
  // acceptance; a cache hit skips BUS and strobes one cycle after acceptance.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    count_d     = count_q;
    ready_d     = 1'b0;
    mem_valid_d = mem_valid_q;
    fault_d     = fault_q;
    abandon_d   = abandon_q;
    unique case (state_q)
      ST_IDLE: begin
        if (walk.valid) begin
          addr_d    = walk.addr;
          abandon_d = 1'b0;
          fault_d   = 1'b0;
          if (count_q != '1) count_d = count_q + 32'd1;
          if (!legal) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = ST_BUS;
          end else if (cache_hit) begin
            rdata_d = cache_data;
            ready_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            mem_valid_d = 1'b1;
            state_d     = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (!walk.valid) abandon_d = 1'b1;
        if (fault_q) begin
          ready_d = walk.valid && !abandon_q;
          state_d = ST_RESP;
        end else if (mem.ready) begin
          rdata_d     = mem.rdata;
          mem_valid_d = 1'b0;
          ready_d     = walk.valid && !abandon_q;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      abandon_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      mem_valid_q <= mem_valid_d;
      fault_q     <= fault_d;
      abandon_q   <= abandon_d;
    end
  end

  assign walk.ready     = ready_q;
  assign walk.rdata     = rdata_q;
  assign mem.valid      = mem_valid_q;
  assign mem.addr       = addr_q;
  assign mem.wstrb      = '0;
  assign walk_req_count = count_q;
endmodule

// File: tb/tb_sv32_walk_mem_responder.sv
// Self-checking bench for sv32_walk_mem_responder (default build and SV32_PTE_CACHE_EN build).
module tb_sv32_walk_mem_responder;
  localparam logic [31:0] PT_BASE = 32'h8000_0000;
  localparam logic [31:0] PT_SIZE = 32'h0800_0000;
  localparam int unsigned NCACHE  = 16;
`ifdef SV32_PTE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tlb_flush = 1'b0;
  logic [31:0] walk_req_count;

  sv32_walk_mem_responder_if walk_if ();
  sv32_walk_mem_responder_if mem_if ();

  sv32_walk_mem_responder #(
    .PT_BASE           (PT_BASE),
    .PT_SIZE           (PT_SIZE),
    .PTE_CACHE_ENTRIES (NCACHE)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .tlb_flush      (tlb_flush),
    .walk           (walk_if),
    .mem            (mem_if),
    .walk_req_count (walk_req_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: request count and a direct-mapped map of word address -> cached PTE.
  logic [31:0] exp_count = '0;
  logic [31:0] cm_addr [NCACHE];
  logic [31:0] cm_data [NCACHE];
  bit          cm_valid[NCACHE];

  function automatic void ref_clear();
    for (int i = 0; i < int'(NCACHE); i++) cm_valid[i] = 1'b0;
  endfunction

  function automatic void ref_expect(input logic [31:0] a, input logic [31:0] d, input int waits,
                                     output int lat, output logic [31:0] data, output bit bus);
    int unsigned i;
    bit fault;
    i = (a >> 2) % NCACHE;
    fault = (a % 4 != 0) || (64'(a) < 64'(PT_BASE)) || (64'(a) >= 64'(PT_BASE) + 64'(PT_SIZE));
    if (fault) begin
      lat = 2; data = '0; bus = 1'b0;
    end else if (CACHE_EN && cm_valid[i] && cm_addr[i] == a) begin
      lat = 1; data = cm_data[i]; bus = 1'b0;
    end else begin
      lat = waits + 2; data = d; bus = 1'b1;
    end
  endfunction

  function automatic void ref_commit(input logic [31:0] a, input logic [31:0] d, input bit bus);
    int unsigned i;
    i = (a >> 2) % NCACHE;
    if (bus) begin
      cm_valid[i] = 1'b1; cm_addr[i] = a; cm_data[i] = d;
    end
    if (exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 1;
  endfunction

  // Walker + bus driver: starts in an IDLE cycle, ends one cycle after the strobe.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input int waits, input bit keep,
                       output int lat, output logic [31:0] got, output bit saw_bus,
                       output bit addr_bad, output bit extra);
    int bc;
    bc = 0; lat = -1; got = '0; saw_bus = 1'b0; addr_bad = 1'b0;
    walk_if.valid = 1'b1;
    walk_if.addr  = a;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (mem_if.valid) begin
        saw_bus = 1'b1;
        if (mem_if.addr !== a) addr_bad = 1'b1;
        bc++;
        mem_if.ready = (bc > waits);
        mem_if.rdata = (bc > waits) ? d : 32'hDEAD_BEEF;
      end else begin
        mem_if.ready = 1'b0;
      end
      if (walk_if.ready) begin
        lat = c; got = walk_if.rdata;
        break;
      end
    end
    mem_if.ready = 1'b0;
    if (!keep) walk_if.valid = 1'b0;
    @(posedge clk); #1;
    extra = walk_if.ready;
  endtask

  task automatic test_reset();
    walk_if.valid = 1'b0; walk_if.addr = '0; walk_if.wstrb = '0;
    mem_if.ready = 1'b0; mem_if.rdata = '0;
    resetn = 1'b0;
    ref_clear();
    exp_count = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (walk_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", walk_if.ready); end
    checks++; if (walk_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", walk_if.rdata); end
    checks++; if (mem_if.valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_if.valid); end
    checks++; if (mem_if.addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_if.addr); end
    checks++; if (walk_req_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", walk_req_count); end
    checks++; if (mem_if.wstrb !== 4'b0000) begin errors++; $display("FAIL wstrb got %b exp 0000", mem_if.wstrb); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    ref_expect(32'h8000_1004, 32'h2000_0401, 3, elat, ed, ebus);
    issue(32'h8000_1004, 32'h2000_0401, 3, 1'b0, lat, got, bus, abad, extra);
    ref_commit(32'h8000_1004, 32'h2000_0401, ebus);
    checks++; if (lat != elat) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, elat); end
    checks++; if (got !== ed) begin errors++; $display("FAIL single_rdata got %h exp %h", got, ed); end
    checks++; if (bus !== ebus || abad) begin errors++; $display("FAIL single_bus got bus=%b addr_bad=%b exp bus=%b", bus, abad, ebus); end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", extra); end
    checks++; if (walk_req_count !== exp_count) begin errors++; $display("FAIL single_count got %0d exp %0d", walk_req_count, exp_count); end
  endtask

  task automatic test_fault();
    logic [31:0] addrs[3];
    int lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    addrs[0] = 32'h8000_1006; addrs[1] = 32'h7FFF_FFFC; addrs[2] = PT_BASE + PT_SIZE;
    foreach (addrs[k]) begin
      ref_expect(addrs[k], 32'h1234_5677, 0, elat, ed, ebus);
      issue(addrs[k], 32'h1234_5677, 0, 1'b0, lat, got, bus, abad, extra);
      ref_commit(addrs[k], 32'h1234_5677, ebus);
      checks++; if (lat != elat) begin errors++; $display("FAIL fault_latency addr %h got %0d exp %0d", addrs[k], lat, elat); end
      checks++; if (got !== ed) begin errors++; $display("FAIL fault_rdata addr %h got %h exp %h", addrs[k], got, ed); end
      checks++; if (bus !== ebus) begin errors++; $display("FAIL fault_bus addr %h got %b exp %b", addrs[k], bus, ebus); end
    end
    checks++; if (walk_req_count !== exp_count) begin errors++; $display("FAIL fault_count got %0d exp %0d", walk_req_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[2], d[2];
    int lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    a[0] = 32'h8000_2000; a[1] = 32'h8000_3008;
    d[0] = 32'h0000_0C01; d[1] = 32'h0004_20CF;
    for (int k = 0; k < 2; k++) begin
      ref_expect(a[k], d[k], k + 1, elat, ed, ebus);
      issue(a[k], d[k], k + 1, (k == 0), lat, got, bus, abad, extra);
      ref_commit(a[k], d[k], ebus);
      checks++; if (lat != elat) begin errors++; $display("FAIL b2b_latency level %0d got %0d exp %0d", k, lat, elat); end
      checks++; if (got !== ed) begin errors++; $display("FAIL b2b_rdata level %0d got %h exp %h", k, got, ed); end
      checks++; if (bus !== ebus || abad || extra) begin errors++; $display("FAIL b2b_bus level %0d got bus=%b addr_bad=%b extra=%b exp bus=%b", k, bus, abad, extra, ebus); end
    end
    checks++; if (walk_req_count !== exp_count) begin errors++; $display("FAIL b2b_count got %0d exp %0d", walk_req_count, exp_count); end
  endtask

  task automatic test_abandon();
    logic [31:0] a, d;
    int bc; bit pulse, served, dropped;
    int lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    a = 32'h8000_4010; d = 32'h0ABC_DE01;
    bc = 0; pulse = 0; served = 0; dropped = 0; abad = 0;
    walk_if.valid = 1'b1; walk_if.addr = a;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (walk_if.ready) pulse = 1'b1;
      if (mem_if.valid) begin
        walk_if.valid = 1'b0;
        if (mem_if.addr !== a) abad = 1'b1;
        bc++;
        mem_if.ready = (bc > 2);
        mem_if.rdata = d;
        if (bc > 2) served = 1'b1;
      end else begin
        if (bc > 0 && !served) dropped = 1'b1;
        mem_if.ready = 1'b0;
      end
    end
    walk_if.valid = 1'b0;
    ref_commit(a, d, 1'b1);
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL abandon_pulse got %b exp 0", pulse); end
    checks++; if (served !== 1'b1 || dropped || abad) begin errors++; $display("FAIL abandon_bus got served=%b dropped=%b addr_bad=%b exp 1 0 0", served, dropped, abad); end
    checks++; if (walk_req_count !== exp_count) begin errors++; $display("FAIL abandon_count got %0d exp %0d", walk_req_count, exp_count); end
    ref_expect(32'h8000_5000, 32'h1111_2221, 1, elat, ed, ebus);
    issue(32'h8000_5000, 32'h1111_2221, 1, 1'b0, lat, got, bus, abad, extra);
    ref_commit(32'h8000_5000, 32'h1111_2221, ebus);
    checks++; if (lat != elat || got !== ed) begin errors++; $display("FAIL abandon_next got lat=%0d rdata=%h exp lat=%0d rdata=%h", lat, got, elat, ed); end
  endtask

  task automatic test_repeat_flush();
    logic [31:0] a;
    int lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    a = 32'h8000_6004;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        tlb_flush = 1'b1;
        @(posedge clk); #1;
        tlb_flush = 1'b0;
        ref_clear();
      end
      ref_expect(a, 32'h0F00_0001 + 32'(k << 4), 2, elat, ed, ebus);
      issue(a, 32'h0F00_0001 + 32'(k << 4), 2, 1'b0, lat, got, bus, abad, extra);
      ref_commit(a, 32'h0F00_0001 + 32'(k << 4), ebus);
      checks++; if (lat != elat) begin errors++; $display("FAIL repeat_latency pass %0d got %0d exp %0d", k, lat, elat); end
      checks++; if (got !== ed) begin errors++; $display("FAIL repeat_rdata pass %0d got %h exp %h", k, got, ed); end
      checks++; if (bus !== ebus) begin errors++; $display("FAIL repeat_bus pass %0d got %b exp %b", k, bus, ebus); end
    end
  endtask

  task automatic test_random();
    logic [31:0] pool[4];
    logic [31:0] a, d;
    int w, lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    pool[0] = PT_BASE + 32'h100; pool[1] = PT_BASE + 32'h140;
    pool[2] = PT_BASE + 32'h104; pool[3] = PT_BASE + PT_SIZE - 32'd4;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1: a = pool[$urandom_range(0, 3)];
        2: a = (PT_BASE + ($urandom & 32'h07FF_FFFC)) | 32'($urandom_range(1, 3));
        3: a = PT_BASE - 32'd4 * 32'($urandom_range(1, 1000));
        4: a = PT_BASE + PT_SIZE + 32'd4 * 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      d = $urandom;
      w = $urandom_range(0, 4);
      ref_expect(a, d, w, elat, ed, ebus);
      issue(a, d, w, 1'b0, lat, got, bus, abad, extra);
      ref_commit(a, d, ebus);
      checks++;
      if (lat != elat || got !== ed || bus !== ebus || abad || extra) begin
        errors++;
        $display("FAIL random addr %h got lat=%0d rdata=%h bus=%b addr_bad=%b extra=%b exp lat=%0d rdata=%h bus=%b",
                 a, lat, got, bus, abad, extra, elat, ed, ebus);
      end
    end
    checks++; if (walk_req_count !== exp_count) begin errors++; $display("FAIL random_count got %0d exp %0d", walk_req_count, exp_count); end
  endtask

  task automatic test_reset_mid_bus();
    int lat, elat; logic [31:0] got, ed; bit bus, ebus, abad, extra;
    walk_if.valid = 1'b1; walk_if.addr = 32'h8000_7000;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (mem_if.valid !== 1'b1) begin errors++; $display("FAIL midbus_setup mem_valid got %b exp 1", mem_if.valid); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (mem_if.valid !== 1'b0 || walk_if.ready !== 1'b0) begin errors++; $display("FAIL midbus_reset_valid got mem_valid=%b ready=%b exp 0 0", mem_if.valid, walk_if.ready); end
    checks++; if (walk_req_count !== 32'h0 || mem_if.addr !== 32'h0) begin errors++; $display("FAIL midbus_reset_regs got count=%0d addr=%h exp 0 0", walk_req_count, mem_if.addr); end
    walk_if.valid = 1'b0;
    exp_count = '0;
    ref_clear();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    ref_expect(32'h8000_7000, 32'h5555_AAA1, 1, elat, ed, ebus);
    issue(32'h8000_7000, 32'h5555_AAA1, 1, 1'b0, lat, got, bus, abad, extra);
    ref_commit(32'h8000_7000, 32'h5555_AAA1, ebus);
    checks++; if (lat != elat || got !== ed || bus !== ebus) begin errors++; $display("FAIL midbus_after got lat=%0d rdata=%h bus=%b exp lat=%0d rdata=%h bus=%b", lat, got, bus, elat, ed, ebus); end
    checks++; if (walk_req_count !== exp_count) begin errors++; $display("FAIL midbus_count got %0d exp %0d", walk_req_count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fault();
    test_back_to_back();
    test_abandon();
    test_repeat_flush();
    test_random();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
